// File: rtl/cache_arbiter.sv
// Two-port (instruction / data) arbiter in front of a shared cache, with
// alternating priority, a per-grant watchdog and saturating stall counters.
module cache_arbiter #(
    parameter int unsigned TIMEOUT = 1023,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_re,
    input  logic [31:0]      i_addr,
    output logic [31:0]      i_rdata,
    output logic             i_done,
    input  logic             d_re,
    input  logic             d_we,
    input  logic [31:0]      d_addr,
    input  logic [31:0]      d_wdata,
    output logic [31:0]      d_rdata,
    output logic             d_done,
    output logic             mem_re,
    output logic             mem_we,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_din,
    input  logic [31:0]      mem_dout,
    input  logic             mem_complete,
    output logic [1:0]       grant,
    output logic             timeout_err,
    output logic [CNT_W-1:0] i_wait_cnt,
    output logic [CNT_W-1:0] d_wait_cnt
);

    // Grant counter only needs to reach TIMEOUT-1: the timeout fires at the end of that cycle.
    localparam int unsigned GNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic             last_d_q;
    logic             last_d_d;
    logic [GNT_W-1:0] gnt_cnt_q;
    logic             timeout_set;
    logic             timeout_hit;
    logic             d_req;

    assign d_req       = d_re | d_we;
    assign timeout_hit = (gnt_cnt_q == GNT_W'(TIMEOUT - 1));

    // State, priority and watchdog registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            last_d_q    <= 1'b0;
            gnt_cnt_q   <= '0;
            timeout_err <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_d_q    <= last_d_d;
            timeout_err <= timeout_err | timeout_set;
            if (state_q == IDLE || state_d == IDLE)
                gnt_cnt_q <= '0;
            else
                gnt_cnt_q <= gnt_cnt_q + GNT_W'(1);
        end
    end

    // Next state and cache-side muxing
    always_comb begin
        state_d     = state_q;
        last_d_d    = last_d_q;
        timeout_set = 1'b0;
        mem_re      = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = '0;
        mem_din     = '0;
        grant       = 2'b00;
        i_done      = 1'b0;
        d_done      = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_re && d_req)
                    state_d = last_d_q ? GNT_I : GNT_D;
                else if (i_re)
                    state_d = GNT_I;
                else if (d_req)
                    state_d = GNT_D;
            end
            GNT_I: begin
                mem_re   = i_re;
                mem_addr = i_addr;
                grant    = 2'b01;
                i_done   = mem_complete & i_re;
                if (i_done) begin
                    state_d  = IDLE;
                    last_d_d = 1'b0;
                end else if (!i_re) begin
                    state_d = IDLE;
                end else if (timeout_hit) begin
                    state_d     = IDLE;
                    timeout_set = 1'b1;
                end
            end
            GNT_D: begin
                mem_re   = d_re;
                mem_we   = d_we;
                mem_addr = d_addr;
                mem_din  = d_wdata;
                grant    = 2'b10;
                d_done   = mem_complete & d_req;
                if (d_done) begin
                    state_d  = IDLE;
                    last_d_d = 1'b1;
                end else if (!d_req) begin
                    state_d = IDLE;
                end else if (timeout_hit) begin
                    state_d     = IDLE;
                    timeout_set = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign i_rdata = i_done ? mem_dout : '0;
    assign d_rdata = d_done ? mem_dout : '0;

    // Stall counters saturate at all-ones
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            i_wait_cnt <= '0;
            d_wait_cnt <= '0;
        end else begin
            if (i_re && !grant[0] && i_wait_cnt != {CNT_W{1'b1}})
                i_wait_cnt <= i_wait_cnt + CNT_W'(1);
            if (d_req && !grant[1] && d_wait_cnt != {CNT_W{1'b1}})
                d_wait_cnt <= d_wait_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_cache_arbiter.sv
// Bench for cache_arbiter: two instances (short watchdog / narrow counters),
// directed vector table, hand sequences and random traffic against a model.
module tb_cache_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_re, d_re, d_we, mem_complete;
    logic [31:0] i_addr, d_addr, d_wdata, mem_dout;

    logic [31:0] i_rdata_w[2], d_rdata_w[2], mem_addr_w[2], mem_din_w[2];
    logic        i_done_w[2], d_done_w[2], mem_re_w[2], mem_we_w[2], terr_w[2];
    logic [1:0]  grant_w[2];
    logic [15:0] iw_a, dw_a;
    logic [3:0]  iw_b, dw_b;
    logic [15:0] iwc[2], dwc[2];

    assign iwc[0] = iw_a;
    assign dwc[0] = dw_a;
    assign iwc[1] = 16'(iw_b);
    assign dwc[1] = 16'(dw_b);

    always #5 clk = ~clk;

    cache_arbiter #(.TIMEOUT(8), .CNT_W(16)) dut_a (
        .clk(clk), .rst(rst),
        .i_re(i_re), .i_addr(i_addr), .i_rdata(i_rdata_w[0]), .i_done(i_done_w[0]),
        .d_re(d_re), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata_w[0]), .d_done(d_done_w[0]),
        .mem_re(mem_re_w[0]), .mem_we(mem_we_w[0]), .mem_addr(mem_addr_w[0]),
        .mem_din(mem_din_w[0]), .mem_dout(mem_dout), .mem_complete(mem_complete),
        .grant(grant_w[0]), .timeout_err(terr_w[0]),
        .i_wait_cnt(iw_a), .d_wait_cnt(dw_a)
    );

    cache_arbiter #(.TIMEOUT(1023), .CNT_W(4)) dut_b (
        .clk(clk), .rst(rst),
        .i_re(i_re), .i_addr(i_addr), .i_rdata(i_rdata_w[1]), .i_done(i_done_w[1]),
        .d_re(d_re), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata_w[1]), .d_done(d_done_w[1]),
        .mem_re(mem_re_w[1]), .mem_we(mem_we_w[1]), .mem_addr(mem_addr_w[1]),
        .mem_din(mem_din_w[1]), .mem_dout(mem_dout), .mem_complete(mem_complete),
        .grant(grant_w[1]), .timeout_err(terr_w[1]),
        .i_wait_cnt(iw_b), .d_wait_cnt(dw_b)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    // Reference model: owner 0=none 1=I 2=D, held = grant cycles elapsed
    int tmo[2]  = '{8, 1023};
    int wmax[2] = '{65535, 15};
    int owner[2], held[2], last_d[2], terr[2], iw[2], dw[2];

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            owner[m] = 0; held[m] = 0; last_d[m] = 0;
            terr[m] = 0; iw[m] = 0; dw[m] = 0;
        end
    endtask

    task automatic model_check();
        logic [1:0]  eg;
        logic        emre, emwe, eid, edd, dreq;
        logic [31:0] eaddr, edin;
        string       t;
        dreq = d_re | d_we;
        for (int m = 0; m < 2; m++) begin
            t     = (m == 0) ? "a" : "b";
            eg    = (owner[m] == 1) ? 2'b01 : (owner[m] == 2) ? 2'b10 : 2'b00;
            emre  = (owner[m] == 1) ? i_re : (owner[m] == 2) ? d_re : 1'b0;
            emwe  = (owner[m] == 2) ? d_we : 1'b0;
            eaddr = (owner[m] == 1) ? i_addr : (owner[m] == 2) ? d_addr : 32'h0;
            edin  = (owner[m] == 2) ? d_wdata : 32'h0;
            eid   = (owner[m] == 1) && mem_complete && i_re;
            edd   = (owner[m] == 2) && mem_complete && dreq;
            chk({t, " grant"},    64'(grant_w[m]),    64'(eg));
            chk({t, " mem_re"},   64'(mem_re_w[m]),   64'(emre));
            chk({t, " mem_we"},   64'(mem_we_w[m]),   64'(emwe));
            chk({t, " mem_addr"}, 64'(mem_addr_w[m]), 64'(eaddr));
            chk({t, " mem_din"},  64'(mem_din_w[m]),  64'(edin));
            chk({t, " i_done"},   64'(i_done_w[m]),   64'(eid));
            chk({t, " d_done"},   64'(d_done_w[m]),   64'(edd));
            chk({t, " i_rdata"},  64'(i_rdata_w[m]),  64'(eid ? mem_dout : 32'h0));
            chk({t, " d_rdata"},  64'(d_rdata_w[m]),  64'(edd ? mem_dout : 32'h0));
            chk({t, " timeout"},  64'(terr_w[m]),     64'(terr[m]));
            chk({t, " i_wait"},   64'(iwc[m]),        64'(iw[m]));
            chk({t, " d_wait"},   64'(dwc[m]),        64'(dw[m]));
        end
    endtask

    task automatic model_step();
        logic dreq;
        dreq = d_re | d_we;
        if (!rst) begin
            model_reset();
            return;
        end
        for (int m = 0; m < 2; m++) begin
            if (i_re && owner[m] != 1 && iw[m] < wmax[m]) iw[m]++;
            if (dreq && owner[m] != 2 && dw[m] < wmax[m]) dw[m]++;
            if (owner[m] == 0) begin
                held[m] = 0;
                if (i_re && dreq) owner[m] = (last_d[m] != 0) ? 1 : 2;
                else if (i_re)    owner[m] = 1;
                else if (dreq)    owner[m] = 2;
            end else begin
                held[m]++;
                if (owner[m] == 1 && mem_complete && i_re) begin
                    owner[m] = 0; last_d[m] = 0;
                end else if (owner[m] == 2 && mem_complete && dreq) begin
                    owner[m] = 0; last_d[m] = 1;
                end else if ((owner[m] == 1 && !i_re) || (owner[m] == 2 && !dreq)) begin
                    owner[m] = 0;
                end else if (held[m] == tmo[m]) begin
                    owner[m] = 0; terr[m] = 1;
                end
            end
        end
    endtask

    // A cycle: inputs set just after posedge, outputs checked at negedge
    task automatic half_a();
        @(negedge clk);
        model_check();
    endtask

    task automatic half_b();
        @(posedge clk);
        model_step();
        #1;
    endtask

    // Asynchronous reset mid-cycle; everything must drop to zero at once
    task automatic do_reset(input int hold);
        rst = 1'b0;
        #1;
        for (int m = 0; m < 2; m++) begin
            chk("rst grant",   64'(grant_w[m]),  64'd0);
            chk("rst mem_re",  64'(mem_re_w[m]), 64'd0);
            chk("rst mem_we",  64'(mem_we_w[m]), 64'd0);
            chk("rst d_done",  64'(d_done_w[m]), 64'd0);
            chk("rst i_done",  64'(i_done_w[m]), 64'd0);
            chk("rst timeout", 64'(terr_w[m]),   64'd0);
            chk("rst i_wait",  64'(iwc[m]),      64'd0);
            chk("rst d_wait",  64'(dwc[m]),      64'd0);
        end
        model_reset();
        for (int k = 0; k < hold; k++) begin
            half_a();
            half_b();
        end
        rst = 1'b1;
    endtask

    typedef struct {
        logic        i_re, d_re, d_we, mc;
        logic [31:0] i_addr, d_addr, d_wdata, mem_dout;
        logic [1:0]  grant;
        logic        mem_re, mem_we;
        logic [31:0] mem_addr, mem_din;
        logic        i_done, d_done;
        logic [31:0] i_rdata, d_rdata;
        logic [15:0] i_wait;
    } vec_t;

    localparam logic        H  = 1'b1;
    localparam logic        L  = 1'b0;
    localparam logic [31:0] Z  = 32'h0;
    localparam logic [31:0] AI = 32'h0000_0040;
    localparam logic [31:0] AD = 32'h0000_0080;
    localparam logic [31:0] AW = 32'h0000_0100;
    localparam logic [31:0] WD = 32'hDEAD_BEEF;
    localparam logic [31:0] D1 = 32'h1111_1111;
    localparam logic [31:0] F1 = 32'h2108_0001;
    localparam logic [31:0] D5 = 32'h5A5A_5A5A;

    vec_t vec[14];

    int gcnt, seen, dd, op, pmc;

    initial begin
        // Simultaneous requests, single fetch with stall, data write
        vec[0]  = '{H,H,L,H, AI,AD,Z,D1,  2'd0,L,L,Z,Z,   L,L,Z,Z,   16'd0};
        vec[1]  = '{H,H,L,H, AI,AD,Z,D1,  2'd2,H,L,AD,Z,  L,H,Z,D1,  16'd1};
        vec[2]  = '{H,L,L,H, AI,AD,Z,D1,  2'd0,L,L,Z,Z,   L,L,Z,Z,   16'd2};
        vec[3]  = '{H,L,L,H, AI,AD,Z,D1,  2'd1,H,L,AI,Z,  H,L,D1,Z,  16'd3};
        vec[4]  = '{L,L,L,H, AI,AD,Z,D1,  2'd0,L,L,Z,Z,   L,L,Z,Z,   16'd3};
        vec[5]  = '{H,L,L,L, AI,AD,Z,F1,  2'd0,L,L,Z,Z,   L,L,Z,Z,   16'd3};
        vec[6]  = '{H,L,L,L, AI,AD,Z,F1,  2'd1,H,L,AI,Z,  L,L,Z,Z,   16'd4};
        vec[7]  = '{H,L,L,L, AI,AD,Z,F1,  2'd1,H,L,AI,Z,  L,L,Z,Z,   16'd4};
        vec[8]  = '{H,L,L,L, AI,AD,Z,F1,  2'd1,H,L,AI,Z,  L,L,Z,Z,   16'd4};
        vec[9]  = '{H,L,L,H, AI,AD,Z,F1,  2'd1,H,L,AI,Z,  H,L,F1,Z,  16'd4};
        vec[10] = '{L,L,L,H, AI,AD,Z,F1,  2'd0,L,L,Z,Z,   L,L,Z,Z,   16'd4};
        vec[11] = '{L,L,H,H, AI,AW,WD,D5, 2'd0,L,L,Z,Z,   L,L,Z,Z,   16'd4};
        vec[12] = '{L,L,H,H, AI,AW,WD,D5, 2'd2,L,H,AW,WD, L,H,Z,D5,  16'd4};
        vec[13] = '{L,L,L,H, AI,AW,WD,D5, 2'd0,L,L,Z,Z,   L,L,Z,Z,   16'd4};

        rst = 1'b0;
        i_re = 1'b0; d_re = 1'b0; d_we = 1'b0; mem_complete = 1'b1;
        i_addr = '0; d_addr = '0; d_wdata = '0; mem_dout = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        for (int m = 0; m < 2; m++) begin
            chk("init grant",   64'(grant_w[m]), 64'd0);
            chk("init timeout", 64'(terr_w[m]),  64'd0);
            chk("init i_wait",  64'(iwc[m]),     64'd0);
        end
        rst = 1'b1;

        for (int k = 0; k < 14; k++) begin
            i_re = vec[k].i_re; d_re = vec[k].d_re; d_we = vec[k].d_we;
            mem_complete = vec[k].mc; i_addr = vec[k].i_addr; d_addr = vec[k].d_addr;
            d_wdata = vec[k].d_wdata; mem_dout = vec[k].mem_dout;
            half_a();
            chk($sformatf("vec%0d grant", k),    64'(grant_w[0]),    64'(vec[k].grant));
            chk($sformatf("vec%0d mem_re", k),   64'(mem_re_w[0]),   64'(vec[k].mem_re));
            chk($sformatf("vec%0d mem_we", k),   64'(mem_we_w[0]),   64'(vec[k].mem_we));
            chk($sformatf("vec%0d mem_addr", k), 64'(mem_addr_w[0]), 64'(vec[k].mem_addr));
            chk($sformatf("vec%0d mem_din", k),  64'(mem_din_w[0]),  64'(vec[k].mem_din));
            chk($sformatf("vec%0d i_done", k),   64'(i_done_w[0]),   64'(vec[k].i_done));
            chk($sformatf("vec%0d d_done", k),   64'(d_done_w[0]),   64'(vec[k].d_done));
            chk($sformatf("vec%0d i_rdata", k),  64'(i_rdata_w[0]),  64'(vec[k].i_rdata));
            chk($sformatf("vec%0d d_rdata", k),  64'(d_rdata_w[0]),  64'(vec[k].d_rdata));
            chk($sformatf("vec%0d i_wait", k),   64'(iwc[0]),        64'(vec[k].i_wait));
            half_b();
        end

        // Watchdog on the TIMEOUT=8 instance
        do_reset(1);
        i_re = 1'b0; d_we = 1'b0; d_re = 1'b1; mem_complete = 1'b0; d_addr = 32'h200;
        gcnt = 0; seen = 0; dd = 0;
        for (int k = 0; k < 12; k++) begin
            half_a();
            if (terr_w[0]) seen = 1;
            else if (grant_w[0] == 2'b10) gcnt++;
            if (d_done_w[0]) dd++;
            half_b();
        end
        chk("wdog grant cycles", 64'(gcnt), 64'd8);
        chk("wdog raised",       64'(seen), 64'd1);
        chk("wdog no done",      64'(dd),   64'd0);
        mem_complete = 1'b1;
        repeat (3) begin half_a(); half_b(); end
        chk("wdog sticky", 64'(terr_w[0]), 64'd1);

        // Reset asserted in the middle of a data write grant
        do_reset(1);
        d_re = 1'b0; d_we = 1'b1; d_wdata = WD; mem_complete = 1'b0;
        repeat (2) begin half_a(); half_b(); end
        chk("midrst pre grant",  64'(grant_w[0]), 64'd2);
        chk("midrst pre mem_we", 64'(mem_we_w[0]), 64'd1);
        mem_complete = 1'b1;
        do_reset(2);
        d_we = 1'b0;

        // Stall-counter saturation on the CNT_W=4 instance
        do_reset(1);
        i_re = 1'b1; d_we = 1'b1; mem_complete = 1'b0;
        repeat (22) begin half_a(); half_b(); end
        chk("sat i_wait", 64'(iwc[1]),     64'd15);
        chk("sat grant",  64'(grant_w[1]), 64'd2);

        // Random traffic
        do_reset(1);
        pmc = 6;
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 399) == 0) do_reset(2);
            if (k % 200 == 0) pmc = $urandom_range(1, 9);
            if ($urandom_range(0, 3) == 0) i_re = ~i_re;
            if ($urandom_range(0, 3) == 0) begin
                op = $urandom_range(0, 2);
                d_re = (op == 1);
                d_we = (op == 2);
            end
            mem_complete = ($urandom_range(0, 9) < pmc);
            i_addr = $urandom; d_addr = $urandom; d_wdata = $urandom; mem_dout = $urandom;
            half_a();
            half_b();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
